// File: rtl/pix_stream_capture.sv
// pix_stream_capture: receive-side endpoint for a strobe-qualified 8-bit pixel
// stream. It tracks the raster position, counts frames, keeps per-frame
// sum/min/max statistics, and captures one armed frame into a buffer that the
// host can read back.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_strb, i_data      pixel valid strobe and 8-bit pixel value
//   i_clr               soft resync (raster, running stats, capture FSM)
//   h_arm               request capture of the next whole frame
//   h_rd, h_addr        host read request and address (row*IMG_W+col)
//   h_rdata, h_rvalid   host read data and valid, one cycle after h_rd
//   o_col, o_row        position of the next expected pixel
//   o_frame_done        one-cycle pulse after the last pixel of a frame
//   o_frame_cnt         completed frame count (wraps)
//   o_sum/o_min/o_max   statistics of the last completed frame
//   o_busy, o_cap_done  capture armed/in progress, buffer holds a full frame
module pix_stream_capture #(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256,
  parameter int unsigned AW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_strb,
  input  logic [7:0]                 i_data,
  input  logic                       i_clr,
  input  logic                       h_arm,
  input  logic                       h_rd,
  input  logic [AW-1:0]              h_addr,
  output logic [7:0]                 h_rdata,
  output logic                       h_rvalid,
  output logic [$clog2(IMG_W)-1:0]   o_col,
  output logic [$clog2(IMG_H)-1:0]   o_row,
  output logic                       o_frame_done,
  output logic [7:0]                 o_frame_cnt,
  output logic [AW+7:0]              o_sum,
  output logic [7:0]                 o_min,
  output logic [7:0]                 o_max,
  output logic                       o_busy,
  output logic                       o_cap_done
);

  localparam int unsigned CW    = $clog2(IMG_W);
  localparam int unsigned RW    = $clog2(IMG_H);
  localparam int unsigned SW    = AW + 8;
  localparam int unsigned DEPTH = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t          state;
  logic [SW-1:0]   rsum;
  logic [7:0]      rmin;
  logic [7:0]      rmax;
  logic [7:0]      mem [DEPTH];

  logic            strb_c;
  logic            last_c;
  logic            origin_c;
  logic            wr_en_c;
  logic [AW-1:0]   wr_addr_c;
  logic [SW-1:0]   sum_fin_c;
  logic [7:0]      min_fin_c;
  logic [7:0]      max_fin_c;

  // A soft resync drops any pixel presented in the same cycle.
  assign strb_c    = i_strb & ~i_clr;
  assign last_c    = (o_col == CW'(IMG_W - 1)) && (o_row == RW'(IMG_H - 1));
  assign origin_c  = (o_col == '0) && (o_row == '0);
  assign wr_addr_c = {o_row, o_col};
  assign wr_en_c   = strb_c && ((state == S_CAPTURE) || ((state == S_ARMED) && origin_c));

  // Statistics including the pixel currently presented.
  assign sum_fin_c = rsum + SW'(i_data);
  assign min_fin_c = (i_data < rmin) ? i_data : rmin;
  assign max_fin_c = (i_data > rmax) ? i_data : rmax;

  // Raster position, running statistics and end-of-frame latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_col        <= '0;
      o_row        <= '0;
      rsum         <= '0;
      rmin         <= 8'hFF;
      rmax         <= 8'h00;
      o_sum        <= '0;
      o_min        <= '0;
      o_max        <= '0;
      o_frame_cnt  <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (i_clr) begin
        o_col <= '0;
        o_row <= '0;
        rsum  <= '0;
        rmin  <= 8'hFF;
        rmax  <= 8'h00;
      end else if (i_strb) begin
        // Power-of-two dimensions: natural wrap brings both counters to 0 on the last pixel.
        o_col <= o_col + CW'(1);
        if (o_col == CW'(IMG_W - 1)) begin
          o_row <= o_row + RW'(1);
        end
        if (last_c) begin
          o_sum        <= sum_fin_c;
          o_min        <= min_fin_c;
          o_max        <= max_fin_c;
          rsum         <= '0;
          rmin         <= 8'hFF;
          rmax         <= 8'h00;
          o_frame_cnt  <= o_frame_cnt + 8'd1;
          o_frame_done <= 1'b1;
        end else begin
          rsum <= sum_fin_c;
          rmin <= min_fin_c;
          rmax <= max_fin_c;
        end
      end
    end
  end

  // Capture FSM; h_arm is only honoured in IDLE and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      o_busy     <= 1'b0;
      o_cap_done <= 1'b0;
    end else if (i_clr) begin
      state  <= S_IDLE;
      o_busy <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (h_arm) begin
            state      <= S_ARMED;
            o_busy     <= 1'b1;
            o_cap_done <= 1'b0;
          end
        end
        S_ARMED: begin
          if (i_strb && origin_c) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (i_strb && last_c) begin
            state      <= S_DONE;
            o_busy     <= 1'b0;
            o_cap_done <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Frame buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_addr_c] <= i_data;
    end
  end

  // Host read port; a same-address write in the same cycle returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_rvalid <= 1'b0;
      h_rdata  <= '0;
    end else begin
      h_rvalid <= h_rd;
      if (h_rd) begin
        h_rdata <= mem[h_addr];
      end
    end
  end

endmodule

// File: tb/tb_pix_stream_capture.sv
// tb_pix_stream_capture: directed self-checking bench for pix_stream_capture
// on a 4x4 raster, with hand-computed expected values.
module tb_pix_stream_capture;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned AW = 4;

  logic           clk;
  logic           rst;
  logic           i_strb;
  logic [7:0]     i_data;
  logic           i_clr;
  logic           h_arm;
  logic           h_rd;
  logic [AW-1:0]  h_addr;
  logic [7:0]     h_rdata;
  logic           h_rvalid;
  logic [1:0]     o_col;
  logic [1:0]     o_row;
  logic           o_frame_done;
  logic [7:0]     o_frame_cnt;
  logic [AW+7:0]  o_sum;
  logic [7:0]     o_min;
  logic [7:0]     o_max;
  logic           o_busy;
  logic           o_cap_done;

  int n_checks;
  int n_fail;
  int done_pulses;

  pix_stream_capture #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_strb       (i_strb),
    .i_data       (i_data),
    .i_clr        (i_clr),
    .h_arm        (h_arm),
    .h_rd         (h_rd),
    .h_addr       (h_addr),
    .h_rdata      (h_rdata),
    .h_rvalid     (h_rvalid),
    .o_col        (o_col),
    .o_row        (o_row),
    .o_frame_done (o_frame_done),
    .o_frame_cnt  (o_frame_cnt),
    .o_sum        (o_sum),
    .o_min        (o_min),
    .o_max        (o_max),
    .o_busy       (o_busy),
    .o_cap_done   (o_cap_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every cycle o_frame_done is high.
  always @(posedge clk) begin
    if (o_frame_done === 1'b1) done_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] d);
    i_strb = 1'b1;
    i_data = d;
    tick();
    i_strb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic arm();
    h_arm = 1'b1;
    tick();
    h_arm = 1'b0;
  endtask

  task automatic check_stats(input string tag, input int s, input int mn, input int mx, input int cnt);
    check({tag, "_sum"}, 32'(o_sum), 32'(s));
    check({tag, "_min"}, 32'(o_min), 32'(mn));
    check({tag, "_max"}, 32'(o_max), 32'(mx));
    check({tag, "_cnt"}, 32'(o_frame_cnt), 32'(cnt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_col"}, 32'(o_col), 32'd0);
    check({tag, "_row"}, 32'(o_row), 32'd0);
    check_stats(tag, 0, 0, 0, 0);
    check({tag, "_done"}, 32'(o_frame_done), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_capdone"}, 32'(o_cap_done), 32'd0);
    check({tag, "_rvalid"}, 32'(h_rvalid), 32'd0);
    check({tag, "_rdata"}, 32'(h_rdata), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    done_pulses = 0;
    rst = 1'b1;
    i_strb = 1'b0;
    i_data = '0;
    i_clr = 1'b0;
    h_arm = 1'b0;
    h_rd = 1'b0;
    h_addr = '0;

    // Reset state
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    done_pulses = 0;

    // Frame of 0..15 with 16 idle cycles between pixels
    for (int i = 0; i < 16; i++) begin
      pix(8'(i));
      if (i == 5) begin
        check("pos_col", 32'(o_col), 32'd2);
        check("pos_row", 32'(o_row), 32'd1);
      end
      if (i < 15) idle(16);
    end
    check("f0_done_hi", 32'(o_frame_done), 32'd1);
    check("f0_wrap_col", 32'(o_col), 32'd0);
    check("f0_wrap_row", 32'(o_row), 32'd0);
    check_stats("f0", 120, 0, 15, 1);
    idle(1);
    check("f0_done_lo", 32'(o_frame_done), 32'd0);
    idle(2);
    check("f0_pulses", 32'(done_pulses), 32'd1);

    // Arm mid-frame: frame 1 is skipped, frame 2 (100+i) is captured
    for (int i = 0; i < 5; i++) pix(8'(i));
    arm();
    check("arm_busy", 32'(o_busy), 32'd1);
    check("arm_capdone", 32'(o_cap_done), 32'd0);
    for (int i = 5; i < 16; i++) pix(8'(i));
    check("f1_busy", 32'(o_busy), 32'd1);
    check("f1_capdone", 32'(o_cap_done), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) h_arm = 1'b1;   // ignored while capturing
      pix(8'(100 + i));
      h_arm = 1'b0;
      if (i == 14) check("f2_capdone_late", 32'(o_cap_done), 32'd0);
    end
    check("f2_capdone", 32'(o_cap_done), 32'd1);
    check("f2_busy", 32'(o_busy), 32'd0);
    check_stats("f2", 1720, 100, 115, 3);
    for (int i = 0; i < 16; i++) begin
      h_rd = 1'b1;
      h_addr = AW'(i);
      tick();
      check("rd_valid", 32'(h_rvalid), 32'd1);
      check("rd_data", 32'(h_rdata), 32'(100 + i));
    end
    h_rd = 1'b0;
    tick();
    check("rd_valid_lo", 32'(h_rvalid), 32'd0);

    // Re-arm from DONE, partial capture, then soft resync with a dropped strobe
    arm();
    check("rearm_capdone", 32'(o_cap_done), 32'd0);
    check("rearm_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 10; i++) pix(8'd50);
    i_clr = 1'b1;
    pix(8'd200);
    i_clr = 1'b0;
    check("clr_col", 32'(o_col), 32'd0);
    check("clr_row", 32'(o_row), 32'd0);
    check("clr_busy", 32'(o_busy), 32'd0);
    check_stats("clr_keep", 1720, 100, 115, 3);
    for (int i = 0; i < 16; i++) pix(8'd7);
    check_stats("sevens", 112, 7, 7, 4);
    check("sevens_capdone", 32'(o_cap_done), 32'd0);

    // Frame counter wrap, then a frame of all FF with an arm on its last pixel
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 16; i++) pix(8'd1);
    end
    check_stats("wrap", 16, 1, 1, 4);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) h_arm = 1'b1;
      pix(8'hFF);
      h_arm = 1'b0;
    end
    check_stats("ff", 4080, 255, 255, 5);
    check("lastarm_busy", 32'(o_busy), 32'd1);

    // Capture with a same-address read/write collision, then reset at pixel 8
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 4) begin
        h_rd = 1'b1;
        h_addr = AW'(3);
      end
      pix(8'(20 + i));
      h_rd = 1'b0;
      if (i == 3) check("collide_old", 32'(h_rdata), 32'd50);
      if (i == 4) check("collide_new", 32'(h_rdata), 32'd23);
    end
    check("cap_busy", 32'(o_busy), 32'd1);
    rst = 1'b1;
    pix(8'd28);
    check_all_zero("midrst");
    rst = 1'b0;
    arm();
    for (int i = 0; i < 16; i++) pix(8'(30 + i));
    check("post_capdone", 32'(o_cap_done), 32'd1);
    check("post_busy", 32'(o_busy), 32'd0);
    check_stats("post", 600, 30, 45, 1);
    for (int k = 0; k < 3; k++) begin
      h_rd = 1'b1;
      h_addr = AW'(k * 7 + (k == 2 ? 1 : 0));   // addresses 0, 7, 15
      tick();
      check("post_rd", 32'(h_rdata), 32'(30 + k * 7 + (k == 2 ? 1 : 0)));
    end
    h_rd = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
